reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Issue-side register scoreboard for variable-latency writebacks (loads, multi-cycle mul/div). Sits at the ID/EX boundary.
- Marks destination registers of in-flight long-latency ops as pending. Stalls ID on RAW/WAW hazards against them.
- Clears pending bits on the completion port. Short-latency hazards stay with the EX-stage forwarding logic; this block only covers results not yet producible by forwarding.

Parameters:
- REG_ADDR_WIDTH, 5, register address width (core_pkg value); NUM_REGS = 2**REG_ADDR_WIDTH.
- MAX_OUTSTANDING, 4, maximum simultaneously pending long-latency ops (1..NUM_REGS-1).

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  asynchronous active-high reset.
- id_valid_i  input  1  valid instruction in ID.
- id_rs1_addr_i  input  REG_ADDR_WIDTH  ID rs1.
- id_rs2_addr_i  input  REG_ADDR_WIDTH  ID rs2.
- id_rs1_used_i  input  1  instruction reads rs1.
- id_rs2_used_i  input  1  instruction reads rs2.
- id_rd_addr_i  input  REG_ADDR_WIDTH  ID rd.
- id_reg_write_i  input  1  instruction writes rd.
- id_long_lat_i  input  1  rd result arrives via completion port.
- flush_i  input  1  ID instruction squashed this cycle (branch/jump redirect).
- cmpl_valid_i  input  1  long-latency result written back this cycle.
- cmpl_rd_addr_i  input  REG_ADDR_WIDTH  destination of completing op.
- stall_o  output  1  hold PC/IF/ID, bubble into EX.
- pending_o  output  NUM_REGS  pending bit vector (bit 0 always 0).
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  count of in-flight ops.
- error_o  output  1  sticky: completion to a non-pending register, or to x0.

Behaviour:
- Reset (async, rst_i=1): pending=0, outstanding=0, error_o=0. stall_o follows combinationally, so it is 0 while rst_i is high.
- clr_vec: one-hot of cmpl_rd_addr_i when cmpl_valid_i and cmpl_rd_addr_i!=0 and that bit is pending; otherwise 0.
- eff_pending = pending & ~clr_vec. A same-cycle completion releases the hazard, because WB data is forwarded.
- RAW condition: id_rs1_used_i and rs1!=0 and eff_pending[rs1]; likewise for rs2.
- WAW condition: id_reg_write_i and rd!=0 and eff_pending[rd].
- Capacity condition: id_long_lat_i and id_reg_write_i and rd!=0 and (outstanding - cmpl_dec) == MAX_OUTSTANDING.
- stall_o = id_valid_i and not flush_i and (RAW or WAW or capacity). Purely combinational, zero latency.
- issue = id_valid_i and not stall_o and not flush_i and id_long_lat_i and id_reg_write_i and rd!=0.
- Next state: pending <= (pending & ~clr_vec) | (issue ? onehot(rd) : 0).
- If set and clear hit the same register in one cycle, set wins. This is reachable only when WAW was released by the completion in that cycle.
- Counter: outstanding <= outstanding + issue - cmpl_dec, where cmpl_dec = |clr_vec. The counter never wraps.
- Invariant: outstanding == popcount(pending). The bench asserts it every cycle.
- error_o sets on cmpl_valid_i with a non-pending rd or rd=0. Sticky until reset. State is otherwise unaffected (no decrement).
- x0: never pending, never causes a stall, never issues.
- flush_i: suppresses issue and stall for the ID instruction only. Already-pending bits persist; in-flight ops still complete.
- Stalled instruction: re-evaluated every cycle with the same inputs. It issues in the first non-stalled cycle.
- Reset mid-operation: all pending cleared immediately. Later completions flag error_o.

Test Plan:
- Load-use: issue long-lat rd=5; next cycle ID reads rs1=5 -> stall_o=1 until completion rd=5. In the completion cycle stall_o=0. pending_o[5] 1->0; outstanding 1->0.
- WAW: pending rd=7; ID short-latency write rd=7 with no source use -> stall_o=1. Release on completion rd=7; the instruction proceeds the same cycle.
- Capacity: MAX_OUTSTANDING=4. Issue rd=1,2,3,4, then a fifth long-lat to rd=6 -> stall_o=1, outstanding_o=4. Complete rd=2 -> fifth issues that cycle; outstanding stays 4; pending has bits {1,3,4,6}.
- Set/clear collision: pending rd=9; completion rd=9 in the same cycle as a new long-lat issue to rd=9 -> no stall, pending_o[9]=1, outstanding_o unchanged at 1.
- x0 and flush: ID rs1=0/rd=0 long-lat -> no stall, no pending. RAW-hazard instruction with flush_i=1 -> stall_o=0, no issue. Completion rd=0 -> error_o=1 and stays 1.
- Async reset: assert rst_i mid-sequence with 3 pending -> pending_o=0, outstanding_o=0, stall_o=0 immediately, without a clock edge. A later completion rd=3 -> error_o=1.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// ID/EX and completion-port signals of the register scoreboard, grouped as one bundle.
// The master side is the pipeline driving ID and writeback; the slave side is the scoreboard.
interface reg_scoreboard_if #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  logic                      id_valid_i;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i;
  logic                      id_rs1_used_i;
  logic                      id_rs2_used_i;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i;
  logic                      id_reg_write_i;
  logic                      id_long_lat_i;
  logic                      flush_i;
  logic                      cmpl_valid_i;
  logic [REG_ADDR_WIDTH-1:0] cmpl_rd_addr_i;
  logic                      stall_o;
  logic [NUM_REGS-1:0]       pending_o;
  logic [CNT_W-1:0]          outstanding_o;
  logic                      error_o;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_addr_i, id_reg_write_i, id_long_lat_i, flush_i,
           cmpl_valid_i, cmpl_rd_addr_i,
    input  stall_o, pending_o, outstanding_o, error_o
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_addr_i, id_reg_write_i, id_long_lat_i, flush_i,
           cmpl_valid_i, cmpl_rd_addr_i,
    output stall_o, pending_o, outstanding_o, error_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Issue-side scoreboard tracking destinations of in-flight long-latency ops.
// Stalls ID on RAW/WAW against pending registers or when the in-flight limit is reached.
module reg_scoreboard #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  reg_scoreboard_if.slave    bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] eff_pending;
  logic [CNT_W-1:0]    outstanding;
  logic [CNT_W-1:0]    net_outstanding;
  logic                error;
  logic                cmpl_dec;
  logic                cmpl_err;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic                capacity;
  logic                long_write;
  logic                stall;
  logic                issue;

  // A completion this cycle releases its register early because WB data is forwarded.
  always_comb begin
    clr_vec = '0;
    if (bus.cmpl_valid_i && (bus.cmpl_rd_addr_i != '0) && pending[bus.cmpl_rd_addr_i])
      clr_vec[bus.cmpl_rd_addr_i] = 1'b1;
    cmpl_dec        = |clr_vec;
    cmpl_err        = bus.cmpl_valid_i &&
                      ((bus.cmpl_rd_addr_i == '0) || !pending[bus.cmpl_rd_addr_i]);
    eff_pending     = pending & ~clr_vec;
    net_outstanding = outstanding - CNT_W'(cmpl_dec);

    long_write = bus.id_long_lat_i && bus.id_reg_write_i && (bus.id_rd_addr_i != '0);
    raw1       = bus.id_rs1_used_i && (bus.id_rs1_addr_i != '0) && eff_pending[bus.id_rs1_addr_i];
    raw2       = bus.id_rs2_used_i && (bus.id_rs2_addr_i != '0) && eff_pending[bus.id_rs2_addr_i];
    waw        = bus.id_reg_write_i && (bus.id_rd_addr_i != '0) && eff_pending[bus.id_rd_addr_i];
    capacity   = long_write && (net_outstanding == CNT_W'(MAX_OUTSTANDING));

    stall = bus.id_valid_i && !bus.flush_i && (raw1 || raw2 || waw || capacity);
    issue = bus.id_valid_i && !stall && !bus.flush_i && long_write;

    set_vec = '0;
    if (issue)
      set_vec[bus.id_rd_addr_i] = 1'b1;
  end

  // Set is OR-ed after clear so a same-cycle reissue to a completing register stays pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending     <= '0;
      outstanding <= '0;
      error       <= 1'b0;
    end else begin
      pending     <= eff_pending | set_vec;
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(cmpl_dec);
      if (cmpl_err)
        error <= 1'b1;
    end
  end

  assign bus.stall_o       = stall;
  assign bus.pending_o     = pending;
  assign bus.outstanding_o = outstanding;
  assign bus.error_o       = error;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: load-use, WAW, capacity, set/clear collision,
// x0/flush handling and asynchronous reset, with the pending/outstanding invariant each cycle.
module tb_reg_scoreboard;
  localparam int AW  = 5;
  localparam int MAX = 4;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  reg_scoreboard_if #(.REG_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAX)) bus ();

  reg_scoreboard #(.REG_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.id_valid_i     = 1'b0;
    bus.id_rs1_addr_i  = '0;
    bus.id_rs2_addr_i  = '0;
    bus.id_rs1_used_i  = 1'b0;
    bus.id_rs2_used_i  = 1'b0;
    bus.id_rd_addr_i   = '0;
    bus.id_reg_write_i = 1'b0;
    bus.id_long_lat_i  = 1'b0;
    bus.flush_i        = 1'b0;
    bus.cmpl_valid_i   = 1'b0;
    bus.cmpl_rd_addr_i = '0;
  endtask

  task automatic id_long(input logic [AW-1:0] rd);
    bus.id_valid_i     = 1'b1;
    bus.id_rd_addr_i   = rd;
    bus.id_reg_write_i = 1'b1;
    bus.id_long_lat_i  = 1'b1;
  endtask

  task automatic cmpl(input logic [AW-1:0] rd);
    bus.cmpl_valid_i   = 1'b1;
    bus.cmpl_rd_addr_i = rd;
  endtask

  // Advances one clock, leaves time at edge+1, and checks count against popcount of pending.
  task automatic cyc();
    int pc;
    @(posedge clk);
    #1;
    pc = 0;
    for (int i = 0; i < 32; i++)
      if (bus.pending_o[i]) pc++;
    vectors++;
    if (int'(bus.outstanding_o) != pc || bus.pending_o[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL invariant: outstanding=%0d pending=%h popcount=%0d",
               bus.outstanding_o, bus.pending_o, pc);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #12;
    vectors++;
    if (bus.pending_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pending: got %h want 0", bus.pending_o); end
    vectors++;
    if (bus.outstanding_o !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_outstanding: got %0d want 0", bus.outstanding_o); end
    vectors++;
    if (bus.error_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error: got %b want 0", bus.error_o); end
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b want 0", bus.stall_o); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_load_use();
    idle();
    id_long(5'd5);
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_issue_stall: got %b want 0", bus.stall_o); end
    cyc();
    vectors++;
    if (bus.pending_o !== 32'h20) begin miscompares++; $display("[TB] FAIL lu_pending_set: got %h want 20", bus.pending_o); end
    vectors++;
    if (bus.outstanding_o !== 3'd1) begin miscompares++; $display("[TB] FAIL lu_out_1: got %0d want 1", bus.outstanding_o); end
    idle();
    bus.id_valid_i = 1'b1; bus.id_rs1_addr_i = 5'd5; bus.id_rs1_used_i = 1'b1;
    bus.id_rd_addr_i = 5'd10; bus.id_reg_write_i = 1'b1;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL lu_stall: got %b want 1", bus.stall_o); end
    cyc();
    vectors++;
    if (bus.stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL lu_stall_hold: got %b want 1", bus.stall_o); end
    cmpl(5'd5);
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_release: got %b want 0", bus.stall_o); end
    cyc();
    vectors++;
    if (bus.pending_o !== 32'h0) begin miscompares++; $display("[TB] FAIL lu_pending_clr: got %h want 0", bus.pending_o); end
    vectors++;
    if (bus.outstanding_o !== 3'd0) begin miscompares++; $display("[TB] FAIL lu_out_0: got %0d want 0", bus.outstanding_o); end
    idle();
  endtask

  task automatic test_waw();
    idle();
    id_long(5'd7);
    cyc();
    idle();
    bus.id_valid_i = 1'b1; bus.id_rd_addr_i = 5'd7; bus.id_reg_write_i = 1'b1;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL waw_stall: got %b want 1", bus.stall_o); end
    cyc();
    cmpl(5'd7);
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL waw_release: got %b want 0", bus.stall_o); end
    cyc();
    vectors++;
    if (bus.pending_o !== 32'h0 || bus.outstanding_o !== 3'd0) begin
      miscompares++; $display("[TB] FAIL waw_final: got pending=%h out=%0d want 0/0", bus.pending_o, bus.outstanding_o);
    end
    idle();
  endtask

  task automatic test_capacity();
    idle();
    for (int r = 1; r <= 4; r++) begin
      id_long(5'(r));
      cyc();
    end
    id_long(5'd6);
    #1;
    vectors++;
    if (bus.stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_stall: got %b want 1", bus.stall_o); end
    vectors++;
    if (bus.outstanding_o !== 3'd4) begin miscompares++; $display("[TB] FAIL cap_out4: got %0d want 4", bus.outstanding_o); end
    vectors++;
    if (bus.pending_o !== 32'h1E) begin miscompares++; $display("[TB] FAIL cap_pending_full: got %h want 1e", bus.pending_o); end
    cyc();
    cmpl(5'd2);
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL cap_release: got %b want 0", bus.stall_o); end
    cyc();
    vectors++;
    if (bus.outstanding_o !== 3'd4) begin miscompares++; $display("[TB] FAIL cap_out_after: got %0d want 4", bus.outstanding_o); end
    vectors++;
    if (bus.pending_o !== 32'h5A) begin miscompares++; $display("[TB] FAIL cap_pending_after: got %h want 5a", bus.pending_o); end
    idle();
    cmpl(5'd1); cyc();
    cmpl(5'd3); cyc();
    cmpl(5'd4); cyc();
    cmpl(5'd6); cyc();
    vectors++;
    if (bus.outstanding_o !== 3'd0 || bus.error_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL cap_drain: got out=%0d err=%b want 0/0", bus.outstanding_o, bus.error_o);
    end
    idle();
  endtask

  task automatic test_collision();
    idle();
    id_long(5'd9);
    cyc();
    cmpl(5'd9);
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL coll_stall: got %b want 0", bus.stall_o); end
    cyc();
    vectors++;
    if (bus.pending_o !== 32'h200) begin miscompares++; $display("[TB] FAIL coll_pending: got %h want 200", bus.pending_o); end
    vectors++;
    if (bus.outstanding_o !== 3'd1) begin miscompares++; $display("[TB] FAIL coll_out: got %0d want 1", bus.outstanding_o); end
    idle();
    cmpl(5'd9);
    cyc();
    idle();
  endtask

  task automatic test_x0_flush();
    idle();
    id_long(5'd0);
    bus.id_rs1_used_i = 1'b1;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL x0_stall: got %b want 0", bus.stall_o); end
    cyc();
    vectors++;
    if (bus.pending_o !== 32'h0 || bus.outstanding_o !== 3'd0) begin
      miscompares++; $display("[TB] FAIL x0_noissue: got pending=%h out=%0d want 0/0", bus.pending_o, bus.outstanding_o);
    end
    idle();
    id_long(5'd12);
    cyc();
    idle();
    id_long(5'd13);
    bus.id_rs1_addr_i = 5'd12; bus.id_rs1_used_i = 1'b1; bus.flush_i = 1'b1;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_stall: got %b want 0", bus.stall_o); end
    cyc();
    vectors++;
    if (bus.pending_o !== 32'h1000 || bus.outstanding_o !== 3'd1) begin
      miscompares++; $display("[TB] FAIL flush_noissue: got pending=%h out=%0d want 1000/1", bus.pending_o, bus.outstanding_o);
    end
    idle();
    cmpl(5'd0);
    cyc();
    vectors++;
    if (bus.error_o !== 1'b1) begin miscompares++; $display("[TB] FAIL x0_cmpl_error: got %b want 1", bus.error_o); end
    vectors++;
    if (bus.pending_o !== 32'h1000 || bus.outstanding_o !== 3'd1) begin
      miscompares++; $display("[TB] FAIL x0_cmpl_state: got pending=%h out=%0d want 1000/1", bus.pending_o, bus.outstanding_o);
    end
    idle();
    cmpl(5'd12);
    cyc();
    idle();
    cyc();
    vectors++;
    if (bus.error_o !== 1'b1 || bus.outstanding_o !== 3'd0) begin
      miscompares++; $display("[TB] FAIL error_sticky: got err=%b out=%0d want 1/0", bus.error_o, bus.outstanding_o);
    end
  endtask

  task automatic test_async_reset();
    idle();
    id_long(5'd3);  cyc();
    id_long(5'd8);  cyc();
    id_long(5'd11); cyc();
    idle();
    bus.id_valid_i = 1'b1; bus.id_rs1_addr_i = 5'd3; bus.id_rs1_used_i = 1'b1;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b1 || bus.outstanding_o !== 3'd3) begin
      miscompares++; $display("[TB] FAIL ar_before: got stall=%b out=%0d want 1/3", bus.stall_o, bus.outstanding_o);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.pending_o !== 32'h0 || bus.outstanding_o !== 3'd0) begin
      miscompares++; $display("[TB] FAIL ar_clear: got pending=%h out=%0d want 0/0", bus.pending_o, bus.outstanding_o);
    end
    vectors++;
    if (bus.stall_o !== 1'b0 || bus.error_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ar_outputs: got stall=%b err=%b want 0/0", bus.stall_o, bus.error_o);
    end
    #1;
    rst = 1'b0;
    idle();
    cmpl(5'd3);
    cyc();
    vectors++;
    if (bus.error_o !== 1'b1 || bus.outstanding_o !== 3'd0) begin
      miscompares++; $display("[TB] FAIL ar_late_cmpl: got err=%b out=%0d want 1/0", bus.error_o, bus.outstanding_o);
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_waw();
    test_capacity();
    test_collision();
    test_x0_flush();
    test_async_reset();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
